// File: rtl/divide_if.sv
// Operand/result bundle for the sequential signed divider.
// The slave modport is the divider itself; master is whoever issues requests.
interface divide_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             ready;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, ready, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, ready, div_by_zero
  );
endinterface

// File: rtl/divide.sv
// Sequential signed restoring divider: one quotient bit per clock on magnitudes,
// then a single fix-up cycle applies signs and the divide-by-zero override.
module divide #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  divide_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   dvsr_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic             dividendNeg_q;
  logic             divisorNeg_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             divByZero_q;
  logic             ready_q;

  logic [WIDTH-1:0] absDividend_d;
  logic [WIDTH:0]   sxDivisor_d;
  logic [WIDTH:0]   absDivisor_d;
  logic [WIDTH+1:0] shifted_d;
  logic [WIDTH+1:0] trial_d;
  logic             trialGe_d;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] remMag_d;
  logic [WIDTH-1:0] quotientSigned_d;
  logic [WIDTH-1:0] remainderSigned_d;

  // The most negative operand's magnitude is 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
  always_comb begin
    absDividend_d     = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    sxDivisor_d       = {bus.divisor[WIDTH-1], bus.divisor};
    absDivisor_d      = bus.divisor[WIDTH-1] ? -sxDivisor_d : sxDivisor_d;
    shifted_d         = {rem_q, quo_q[WIDTH-1]};
    trial_d           = shifted_d - {1'b0, dvsr_q};
    trialGe_d         = ~trial_d[WIDTH+1];
    rem_d             = trialGe_d ? trial_d[WIDTH:0] : shifted_d[WIDTH:0];
    quo_d             = {quo_q[WIDTH-2:0], trialGe_d};
    remMag_d          = rem_q[WIDTH-1:0];
    quotientSigned_d  = (dividendNeg_q ^ divisorNeg_q) ? -quo_q : quo_q;
    remainderSigned_d = dividendNeg_q ? -remMag_d : remMag_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      quo_q         <= '0;
      dvsr_q        <= '0;
      dividend_q    <= '0;
      divisor_q     <= '0;
      dividendNeg_q <= 1'b0;
      divisorNeg_q  <= 1'b0;
      count_q       <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      divByZero_q   <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            dividend_q    <= bus.dividend;
            divisor_q     <= bus.divisor;
            dividendNeg_q <= bus.dividend[WIDTH-1];
            divisorNeg_q  <= bus.divisor[WIDTH-1];
            quo_q         <= absDividend_d;
            dvsr_q        <= absDivisor_d;
            rem_q         <= '0;
            count_q       <= '0;
            ready_q       <= 1'b0;
            state_q       <= CALC;
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          // A zero divisor overrides the iterated magnitudes entirely.
          if (divisor_q == '0) begin
            quotient_q  <= '1;
            remainder_q <= dividend_q;
            divByZero_q <= 1'b1;
          end else begin
            quotient_q  <= quotientSigned_d;
            remainder_q <= remainderSigned_d;
            divByZero_q <= 1'b0;
          end
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = divByZero_q;
  assign bus.ready       = ready_q;
endmodule

// File: tb/tb_divide.sv
// Scoreboard bench for the signed divider: stimulus queues expected results,
// a negedge monitor pops and compares each time ready rises.
module tb_divide;
  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divByZero;
  } expect_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  expect_t sbQueue[$];

  divide_if #(.WIDTH(WIDTH)) bus ();

  divide #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives operands and a one-cycle start pulse; caller must be at a negedge.
  task automatic startOp(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic waitReady();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * LATENCY; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL readyTimeout: got ready=0, expected ready=1 within %0d cycles", 4 * LATENCY);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                               input logic [WIDTH-1:0] expQ, input logic [WIDTH-1:0] expR,
                               input logic expDbz);
    sbQueue.push_back('{quotient: expQ, remainder: expR, divByZero: expDbz});
    startOp(dvd, dvs);
    waitReady();
  endtask

  // Monitor: tracks busy length, checks outputs hold while busy, scores each completion.
  logic             prevReady;
  int               busyCycles;
  logic [WIDTH-1:0] heldQ;
  logic [WIDTH-1:0] heldR;
  logic             heldDbz;
  expect_t          exp;

  always @(negedge clk) begin
    if (reset) begin
      prevReady  = 1'b1;
      busyCycles = 0;
      heldQ      = '0;
      heldR      = '0;
      heldDbz    = 1'b0;
    end else if (bus.ready !== 1'b1) begin
      busyCycles++;
      checkOutput("holdQuotient", bus.quotient, heldQ);
      checkOutput("holdRemainder", bus.remainder, heldR);
      checkOutput("holdDivByZero", WIDTH'(bus.div_by_zero), WIDTH'(heldDbz));
      prevReady = 1'b0;
    end else begin
      if (!prevReady) begin
        checkOutput("latency", WIDTH'(busyCycles), WIDTH'(LATENCY));
        if (sbQueue.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedResult: got quotient 0x%08h, expected no completion", bus.quotient);
        end else begin
          exp = sbQueue.pop_front();
          checkOutput("quotient", bus.quotient, exp.quotient);
          checkOutput("remainder", bus.remainder, exp.remainder);
          checkOutput("divByZero", WIDTH'(bus.div_by_zero), WIDTH'(exp.divByZero));
        end
        heldQ   = bus.quotient;
        heldR   = bus.remainder;
        heldDbz = bus.div_by_zero;
      end
      prevReady  = 1'b1;
      busyCycles = 0;
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (3) @(negedge clk);
    checkOutput("resetReady", WIDTH'(bus.ready), WIDTH'(1));
    checkOutput("resetQuotient", bus.quotient, '0);
    checkOutput("resetRemainder", bus.remainder, '0);
    checkOutput("resetDivByZero", WIDTH'(bus.div_by_zero), '0);
    #2 reset = 1'b0;
    @(negedge clk);

    applyStimulus(32'd60, 32'd3, 32'd20, 32'd0, 1'b0);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    applyStimulus(32'hFFFF_FFE9, 32'hFFFF_FFFF, 32'd23, 32'd0, 1'b0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0);
    applyStimulus(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    applyStimulus(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    applyStimulus(32'd9, 32'd4, 32'd2, 32'd1, 1'b0);
    applyStimulus(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    // A second start mid-CALC with new operands must be ignored.
    sbQueue.push_back('{quotient: 32'd14, remainder: 32'd2, divByZero: 1'b0});
    startOp(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    startOp(32'd1, 32'd1);
    waitReady();

    // Reset mid-operation aborts and clears outputs immediately.
    startOp(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abortReady", WIDTH'(bus.ready), WIDTH'(1));
    checkOutput("abortQuotient", bus.quotient, '0);
    checkOutput("abortRemainder", bus.remainder, '0);
    checkOutput("abortDivByZero", WIDTH'(bus.div_by_zero), '0);
    @(negedge clk);
    #2 reset = 1'b0;
    applyStimulus(32'd60, 32'd3, 32'd20, 32'd0, 1'b0);

    @(negedge clk);
    checkOutput("scoreboardDrained", WIDTH'(sbQueue.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
